// File: rtl/banco_reg_if.sv
// Register-file access bundle: one write port and two combinational read ports.
// The master drives the write and read addresses; the slave returns the read data.
interface banco_reg_if #(
    parameter int WIDTH = 32
);
    logic             regwrite;
    logic [4:0]       wa;
    logic [WIDTH-1:0] wd;
    logic [4:0]       ra1;
    logic [4:0]       ra2;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;

    modport master (
        output regwrite, wa, wd, ra1, ra2,
        input  rd1, rd2
    );

    modport slave (
        input  regwrite, wa, wd, ra1, ra2,
        output rd1, rd2
    );
endinterface

// File: rtl/banco_reg.sv
// Register file: NREG x WIDTH, one write port, two zero-latency read ports, r0 hardwired to 0.
// Optional macro BANCO_REG_BYPASS_EN makes a same-cycle write visible on the read ports.
module banco_reg #(
    parameter int WIDTH = 32,
    parameter int NREG  = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    banco_reg_if.slave bus
);

    // All 32 addressable slots exist on the read side; unimplemented ones are constant 0.
    logic [WIDTH-1:0] rf [32];
    logic [31:0]      hit;

    if (NREG < 1 || NREG > 32) begin : g_bad_nreg
        $error("banco_reg: NREG must be in 1..32");
    end

    for (genvar g = 0; g < 32; g++) begin : g_reg
        if (g == 0 || g >= NREG) begin : g_zero
            assign hit[g] = 1'b0;
            assign rf[g]  = '0;
        end else begin : g_live
            logic [WIDTH-1:0] q;

            assign hit[g] = bus.regwrite && (bus.wa == 5'(g));

            // NOTE: every storage word sits on the async reset; a reset must wipe all prior
            // writes at once, so this array is built from flops, not an inferred RAM macro.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q <= '0;
                end else if (hit[g]) begin
                    q <= bus.wd;
                end
            end

            assign rf[g] = q;
        end
    end

`ifdef BANCO_REG_BYPASS_EN
    // Write-first forwarding; hit[] is never set for r0 or absent registers, and reset gates it.
    assign bus.rd1 = (rst_n && hit[bus.ra1]) ? bus.wd : rf[bus.ra1];
    assign bus.rd2 = (rst_n && hit[bus.ra2]) ? bus.wd : rf[bus.ra2];
`else
    assign bus.rd1 = rf[bus.ra1];
    assign bus.rd2 = rf[bus.ra2];
`endif

endmodule

// File: tb/tb_banco_reg.sv
// Self-checking bench for banco_reg: directed vector table plus reset/bypass corner sequences.
module tb_banco_reg;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    banco_reg_if #(.WIDTH(32)) bus ();

    banco_reg #(.WIDTH(32), .NREG(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rw;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rw, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra1, input logic [4:0] ra2);
        bus.regwrite = rw;
        bus.wa       = wa;
        bus.wd       = wd;
        bus.ra1      = ra1;
        bus.ra2      = ra2;
    endtask

    initial begin
        logic [31:0] exp_byp;
        checks   = 0;
        failures = 0;

        vecs[0] = '{1'b1, 5'd7,  32'hDEADBEEF, 5'd7,  5'd7,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd7,  32'h0,        32'hDEADBEEF};
        vecs[2] = '{1'b0, 5'd9,  32'hA5A5A5A5, 5'd9,  5'd0,  32'h0,        32'h0};
        vecs[3] = '{1'b1, 5'd31, 32'h12345678, 5'd31, 5'd7,  32'h12345678, 32'hDEADBEEF};
        vecs[4] = '{1'b1, 5'd1,  32'h00000001, 5'd1,  5'd31, 32'h00000001, 32'h12345678};
        vecs[5] = '{1'b1, 5'd7,  32'hCAFEF00D, 5'd7,  5'd1,  32'hCAFEF00D, 32'h00000001};
        vecs[6] = '{1'b0, 5'd7,  32'h00000000, 5'd7,  5'd31, 32'hCAFEF00D, 32'h12345678};
        vecs[7] = '{1'b1, 5'd3,  32'h00000001, 5'd3,  5'd9,  32'h00000001, 32'h0};
        vecs[8] = '{1'b1, 5'd9,  32'hA5A5A5A5, 5'd9,  5'd9,  32'hA5A5A5A5, 32'hA5A5A5A5};
        vecs[9] = '{1'b1, 5'd31, 32'h00000000, 5'd31, 5'd1,  32'h00000000, 32'h00000001};

        // Reset with no clock edge yet.
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd31);
        #1;
        check("reset_rd1", bus.rd1, 32'h0);
        check("reset_rd2", bus.rd2, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(vecs[i].rw, vecs[i].wa, vecs[i].wd, vecs[i].ra1, vecs[i].ra2);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_rd1", i), bus.rd1, vecs[i].exp1);
            check($sformatf("vec%0d_rd2", i), bus.rd2, vecs[i].exp2);
        end

        // Same-cycle write/read of r3 (holds 1): bypass decides the pre-edge value.
        @(negedge clk);
        drive(1'b1, 5'd3, 32'h55, 5'd7, 5'd3);
`ifdef BANCO_REG_BYPASS_EN
        exp_byp = 32'h55;
`else
        exp_byp = 32'h1;
`endif
        #1;
        check("byp_pre_rd2", bus.rd2, exp_byp);
        check("byp_pre_rd1_other", bus.rd1, 32'hCAFEF00D);
        @(posedge clk);
        #1;
        check("byp_post_rd2", bus.rd2, 32'h55);

        // Write to r0 never forwards.
        @(negedge clk);
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        #1;
        check("r0_pre_rd1", bus.rd1, 32'h0);
        @(posedge clk);
        #1;
        check("r0_post_rd1", bus.rd1, 32'h0);

        // Write r4, then asynchronous reset pulse between edges.
        @(negedge clk);
        drive(1'b1, 5'd4, 32'h1234, 5'd4, 5'd7);
        @(posedge clk);
        #1;
        check("r4_written", bus.rd1, 32'h1234);
        @(negedge clk);
        drive(1'b1, 5'd5, 32'hBAD0BAD0, 5'd4, 5'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_rd1", bus.rd1, 32'h0);
        check("rst_byp_blocked_rd2", bus.rd2, 32'h0);
        bus.ra2 = 5'd7;
        #1;
        check("rst_clears_r7", bus.rd2, 32'h0);
        @(posedge clk);
        #1;
        check("rst_blocks_write", bus.rd2, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 5'd4, 32'h77, 5'd4, 5'd5);
        @(posedge clk);
        #1;
        check("post_rst_write", bus.rd1, 32'h77);
        check("post_rst_r5_empty", bus.rd2, 32'h0);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd31);
        #1;
        check("post_rst_r9", bus.rd1, 32'h0);
        check("post_rst_r31", bus.rd2, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
